// File: rtl/dmem_responder.sv
// Data-memory responder: word/byte load/store with WAIT_CYCLES wait states before a one-cycle
// ready response. Define DMEM_ALIGN_CHECK_EN to fault misaligned word accesses.
module dmem_responder #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic        byte_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        fault
);

   localparam int unsigned IW       = $clog2(DEPTH);
   localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          hold_we_q, hold_we_d;
   logic          hold_byte_q, hold_byte_d;
   logic [31:0]   hold_addr_q, hold_addr_d;
   logic [31:0]   hold_wdata_q, hold_wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          ready_q, ready_d;
   logic          fault_q, fault_d;

   logic [31:0]   mem_q [DEPTH];

   logic          accept;
   logic          enter_resp;
   logic          cur_we;
   logic          cur_byte;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic [IW-1:0] cur_idx;
   logic [1:0]    cur_lane;
   logic          misalign;
   logic          mem_we;
   logic [31:0]   rd_word;
   logic [7:0]    rd_byte;
   logic          unused_addr;

   assign accept = req && ((state_q == StIdle) || (state_q == StResp));

   // With no wait states the response edge is the acceptance edge, so the live inputs are used.
   assign cur_we    = (state_q == StWait) ? hold_we_q    : we;
   assign cur_byte  = (state_q == StWait) ? hold_byte_q  : byte_en;
   assign cur_addr  = (state_q == StWait) ? hold_addr_q  : addr;
   assign cur_wdata = (state_q == StWait) ? hold_wdata_q : wdata;
   assign cur_idx   = cur_addr[IW+1:2];
   assign cur_lane  = cur_addr[1:0];

   assign unused_addr = ^cur_addr[31:IW+2];

   assign enter_resp = (accept && (WaitLoad == 4'd0)) ||
                       ((state_q == StWait) && (cnt_q == 4'd1));

`ifdef DMEM_ALIGN_CHECK_EN
   assign misalign = !cur_byte && (cur_lane != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // Reset dominates: a response edge coinciding with reset commits nothing.
   assign mem_we = enter_resp && cur_we && !misalign && !reset;

   assign rd_word = mem_q[cur_idx];

   always_comb begin
      rd_byte = 8'h00;
      unique case (cur_lane)
         2'd0: rd_byte = rd_word[7:0];
         2'd1: rd_byte = rd_word[15:8];
         2'd2: rd_byte = rd_word[23:16];
         2'd3: rd_byte = rd_word[31:24];
         default: rd_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hold_we_d    = hold_we_q;
      hold_byte_d  = hold_byte_q;
      hold_addr_d  = hold_addr_q;
      hold_wdata_d = hold_wdata_q;
      rdata_d      = 32'h0;
      ready_d      = 1'b0;
      fault_d      = 1'b0;

      unique case (state_q)
         StIdle, StResp: begin
            if (accept) begin
               hold_we_d    = we;
               hold_byte_d  = byte_en;
               hold_addr_d  = addr;
               hold_wdata_d = wdata;
               if (WaitLoad == 4'd0) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = WaitLoad;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StResp;
            end
         end
         default: state_d = StIdle;
      endcase

      if (enter_resp) begin
         ready_d = 1'b1;
         fault_d = misalign;
         if (!cur_we && !misalign) begin
            rdata_d = cur_byte ? {24'h0, rd_byte} : rd_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         hold_we_q    <= 1'b0;
         hold_byte_q  <= 1'b0;
         hold_addr_q  <= 32'h0;
         hold_wdata_q <= 32'h0;
         rdata_q      <= 32'h0;
         ready_q      <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hold_we_q    <= hold_we_d;
         hold_byte_q  <= hold_byte_d;
         hold_addr_q  <= hold_addr_d;
         hold_wdata_q <= hold_wdata_d;
         rdata_q      <= rdata_d;
         ready_q      <= ready_d;
         fault_q      <= fault_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         if (cur_byte) begin
            unique case (cur_lane)
               2'd0: mem_q[cur_idx][7:0]   <= cur_wdata[7:0];
               2'd1: mem_q[cur_idx][15:8]  <= cur_wdata[7:0];
               2'd2: mem_q[cur_idx][23:16] <= cur_wdata[7:0];
               2'd3: mem_q[cur_idx][31:24] <= cur_wdata[7:0];
               default: ;
            endcase
         end else begin
            mem_q[cur_idx] <= cur_wdata;
         end
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign fault = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed stores/loads push expected responses; a negedge
// monitor checks every ready pulse for data, fault and arrival cycle.
module tb_dmem_responder;

   localparam int unsigned WAIT = 1;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we;
   logic        byte_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        fault;

   exp_t exp_q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit AlignChk = 1'b1;
`else
   localparam bit AlignChk = 1'b0;
`endif

   dmem_responder #(
      .DEPTH      (64),
      .WAIT_CYCLES(WAIT)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .we     (we),
      .byte_en(byte_en),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .ready  (ready),
      .fault  (fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every ready pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_ready: cyc=%0d rdata=%08h fault=%0b, required no response",
                        cyc, rdata, fault);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (rdata !== e.rdata || fault !== e.fault || cyc != e.due) begin
                  bad++;
                  $display("FAIL response: got rdata=%08h fault=%0b cyc=%0d, required %08h %0b %0d",
                           rdata, fault, cyc, e.rdata, e.fault, e.due);
               end
            end
         end else begin
            total++;
            if (rdata !== 32'h0 || fault !== 1'b0) begin
               bad++;
               $display("FAIL idle_outputs: cyc=%0d rdata=%08h fault=%0b, required 0 0",
                        cyc, rdata, fault);
            end
         end
      end
   end

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: ready=%0b after %0d cycles, required 1", tag, ready, n);
      end
   endtask

   task automatic drive(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d);
      we      = w;
      byte_en = b;
      addr    = a;
      wdata   = d;
      req     = 1'b1;
   endtask

   task automatic issue(input string tag, input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_f);
      @(negedge clk);
      drive(w, b, a, d);
      exp_q.push_back('{exp_rd, exp_f, cyc + 1 + int'(WAIT)});
      @(posedge clk);
      #1;
      req   = 1'b0;
      addr  = 32'hXXXX_XXXX;
      wdata = 32'hXXXX_XXXX;
      wait_ready(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      req     = 1'b0;
      we      = 1'b0;
      byte_en = 1'b0;
      addr    = 32'h0;
      wdata   = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (ready !== 1'b0 || rdata !== 32'h0 || fault !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: ready=%0b rdata=%08h fault=%0b, required 0 0 0",
                  ready, rdata, fault);
      end
      reset = 1'b0;

      issue("st_beef", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      issue("ld_beef", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

      issue("st_1122", 1'b1, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0);
      issue("stb_5a", 1'b1, 1'b1, 32'h13, 32'hFFFFFF5A, 32'h0, 1'b0);
      issue("ld_5a22", 1'b0, 1'b0, 32'h10, 32'h0, 32'h5A223344, 1'b0);
      issue("ldb_13", 1'b0, 1'b1, 32'h13, 32'h0, 32'h0000005A, 1'b0);
      issue("ldb_11", 1'b0, 1'b1, 32'h11, 32'h0, 32'h00000033, 1'b0);

      // Back-to-back: the load is presented during the store's RESP cycle.
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h20, 32'hCAFEF00D);
      exp_q.push_back('{32'h0, 1'b0, cyc + 1 + int'(WAIT)});
      @(posedge clk);
      #1;
      wait_ready("b2b_st");
      if (ready) begin
         drive(1'b0, 1'b0, 32'h20, 32'h0);
         exp_q.push_back('{32'hCAFEF00D, 1'b0, cyc + 1 + int'(WAIT)});
         @(posedge clk);
         #1;
         req = 1'b0;
         wait_ready("b2b_ld");
      end

      issue("st_wrap", 1'b1, 1'b0, 32'h100, 32'h0000ABCD, 32'h0, 1'b0);
      issue("ld_wrap", 1'b0, 1'b0, 32'h000, 32'h0, 32'h0000ABCD, 1'b0);

      // Reset during WAIT discards the pending store.
      issue("st_0102", 1'b1, 1'b0, 32'h08, 32'h01020304, 32'h0, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h08, 32'hFFFFFFFF);
      @(posedge clk);
      #1;
      req   = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (ready !== 1'b0 || rdata !== 32'h0 || fault !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: ready=%0b rdata=%08h fault=%0b, required 0 0 0",
                  ready, rdata, fault);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      issue("ld_0102", 1'b0, 1'b0, 32'h08, 32'h0, 32'h01020304, 1'b0);

      // Misaligned word accesses.
      issue("st_mis", 1'b1, 1'b0, 32'h22, 32'h12345678, 32'h0, AlignChk);
      issue("ld_20", 1'b0, 1'b0, 32'h20, 32'h0,
            AlignChk ? 32'hCAFEF00D : 32'h12345678, 1'b0);
      issue("ld_mis", 1'b0, 1'b0, 32'h22, 32'h0,
            AlignChk ? 32'h0 : 32'h12345678, AlignChk);
      issue("ldb_22", 1'b0, 1'b1, 32'h22, 32'h0,
            AlignChk ? 32'h000000FE : 32'h00000034, 1'b0);

      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
